// File: rtl/apple_gen.sv
// apple_gen: picks a free pseudo-random playfield cell for the apple overlay.
// Ports: pclk/rst_n clock and async active-low reset; start/eaten request a new apple;
// occ_req/occ_x/occ_y out and occ_ack/occ_hit in form the snake occupancy query;
// apple_x/apple_y/apple_valid publish the placed apple; busy while searching;
// fail once MAX_TRIES consecutive candidates were occupied.
module apple_gen #(
  parameter int          GRID_W    = 32,
  parameter int          GRID_H    = 24,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          MAX_TRIES = 64
) (
  input  logic       pclk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       eaten,
  output logic       occ_req,
  output logic [6:0] occ_x,
  output logic [5:0] occ_y,
  input  logic       occ_ack,
  input  logic       occ_hit,
  output logic [6:0] apple_x,
  output logic [5:0] apple_y,
  output logic       apple_valid,
  output logic       busy,
  output logic       fail
);
  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_CHECK, S_FAIL} state_t;
  state_t      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [7:0]  tries_q, tries_d;
  logic        occ_req_q, occ_req_d, apple_valid_q, apple_valid_d;
  logic        busy_q, busy_d, fail_q, fail_d;
  logic [6:0]  occ_x_q, occ_x_d, apple_x_q, apple_x_d;
  logic [5:0]  occ_y_q, occ_y_d, apple_y_q, apple_y_d;
  logic        in_range;
  // compared at 8 bits so GRID_W=128 is representable
  assign in_range = ({1'b0, lfsr_q[6:0]} < 8'(GRID_W)) && ({2'b0, lfsr_q[13:8]} < 8'(GRID_H));
  always_comb begin
    state_d       = state_q;
    lfsr_d        = lfsr_q[0] ? (lfsr_q >> 1) ^ 16'hB400 : lfsr_q >> 1;
    tries_d       = tries_q;
    occ_req_d     = occ_req_q;
    occ_x_d       = occ_x_q;
    occ_y_d       = occ_y_q;
    apple_x_d     = apple_x_q;
    apple_y_d     = apple_y_q;
    apple_valid_d = apple_valid_q;
    busy_d        = busy_q;
    fail_d        = fail_q;
    case (state_q)
      S_IDLE: if (start || eaten) begin
        state_d       = S_DRAW;
        apple_valid_d = 1'b0;
        tries_d       = 8'd0;
        busy_d        = 1'b1;
      end
      S_DRAW: if (start) tries_d = 8'd0;
      else if (in_range) begin
        occ_x_d   = lfsr_q[6:0];
        occ_y_d   = lfsr_q[13:8];
        occ_req_d = 1'b1;
        state_d   = S_CHECK;
      end
      // a restart withdraws the query and wins over an ack in the same cycle
      S_CHECK: if (start) begin
        occ_req_d = 1'b0;
        tries_d   = 8'd0;
        state_d   = S_DRAW;
      end else if (occ_ack) begin
        occ_req_d = 1'b0;
        if (!occ_hit) begin
          apple_x_d     = occ_x_q;
          apple_y_d     = occ_y_q;
          apple_valid_d = 1'b1;
          busy_d        = 1'b0;
          state_d       = S_IDLE;
        end else if (tries_q == 8'(MAX_TRIES - 1)) begin
          fail_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_FAIL;
        end else begin
          tries_d = tries_q + 8'd1;
          state_d = S_DRAW;
        end
      end
      S_FAIL: if (start) begin
        fail_d  = 1'b0;
        tries_d = 8'd0;
        busy_d  = 1'b1;
        state_d = S_DRAW;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge pclk or negedge rst_n)
    if (!rst_n) begin
      state_q       <= S_IDLE;
      lfsr_q        <= LFSR_SEED;
      tries_q       <= 8'd0;
      occ_req_q     <= 1'b0;
      occ_x_q       <= 7'd0;
      occ_y_q       <= 6'd0;
      apple_x_q     <= 7'd0;
      apple_y_q     <= 6'd0;
      apple_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      fail_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      lfsr_q        <= lfsr_d;
      tries_q       <= tries_d;
      occ_req_q     <= occ_req_d;
      occ_x_q       <= occ_x_d;
      occ_y_q       <= occ_y_d;
      apple_x_q     <= apple_x_d;
      apple_y_q     <= apple_y_d;
      apple_valid_q <= apple_valid_d;
      busy_q        <= busy_d;
      fail_q        <= fail_d;
    end
  assign occ_req     = occ_req_q;
  assign occ_x       = occ_x_q;
  assign occ_y       = occ_y_q;
  assign apple_x     = apple_x_q;
  assign apple_y     = apple_y_q;
  assign apple_valid = apple_valid_q;
  assign busy        = busy_q;
  assign fail        = fail_q;
endmodule

// File: tb/tb_apple_gen.sv
// tb_apple_gen: scoreboard bench for apple_gen (32x24 grid, MAX_TRIES=4) plus a 5x3 coverage instance.
module tb_apple_gen;
  localparam int MT = 4;
  logic pclk = 1'b0, rst_n = 1'b1, s_rst_n = 1'b1;
  logic start = 1'b0, eaten = 1'b0, occ_ack = 1'b0, occ_hit = 1'b0;
  logic occ_req, apple_valid, busy, fail;
  logic [6:0] occ_x, apple_x;
  logic [5:0] occ_y, apple_y;
  logic s_start = 1'b0, s_eaten = 1'b0, s_req, s_valid, s_busy, s_fail;
  logic [6:0] s_x, s_ax;
  logic [5:0] s_y, s_ay;
  int n_cmp = 0, n_bad = 0, q_count = 0, hi_count = 0;
  int cur_x, cur_y, cur_n, lat_k, lat_n;
  typedef struct {int kind; int x; int y;} ev_t;
  ev_t exp_q[$];
  logic [15:0] m_lfsr;
  logic prev_req = 1'b0, prev_av = 1'b0, prev_fail = 1'b0, s_prev = 1'b0;
  logic [6:0] hold_x = 7'd0;
  logic [5:0] hold_y = 6'd0;

  always #5 pclk = ~pclk;

  apple_gen #(.MAX_TRIES(MT)) dut (
    .pclk(pclk), .rst_n(rst_n), .start(start), .eaten(eaten),
    .occ_req(occ_req), .occ_x(occ_x), .occ_y(occ_y), .occ_ack(occ_ack), .occ_hit(occ_hit),
    .apple_x(apple_x), .apple_y(apple_y), .apple_valid(apple_valid), .busy(busy), .fail(fail)
  );

  apple_gen #(.GRID_W(5), .GRID_H(3)) u_sm (
    .pclk(pclk), .rst_n(s_rst_n), .start(s_start), .eaten(s_eaten),
    .occ_req(s_req), .occ_x(s_x), .occ_y(s_y), .occ_ack(s_req), .occ_hit(1'b0),
    .apple_x(s_ax), .apple_y(s_ay), .apple_valid(s_valid), .busy(s_busy), .fail(s_fail)
  );

  function automatic logic [15:0] nx(input logic [15:0] s);
    return s[0] ? (s >> 1) ^ 16'hB400 : s >> 1;
  endfunction

  // reference LFSR running alongside the DUT
  always @(posedge pclk or negedge rst_n)
    if (!rst_n) m_lfsr <= 16'hACE1;
    else m_lfsr <= nx(m_lfsr);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic pop(input int kind, input int x, input int y, input string nm);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: unexpected event (%0d,%0d), nothing expected", nm, x, y);
      return;
    end
    e = exp_q.pop_front();
    chk({nm, "_kind"}, kind, e.kind);
    chk({nm, "_x"}, x, e.x);
    chk({nm, "_y"}, y, e.y);
  endtask

  // first in-range candidate from the LFSR value the DUT sees this DRAW cycle
  task automatic predict();
    logic [15:0] s;
    int n;
    s = m_lfsr;
    n = 1;
    while (!(({1'b0, s[6:0]} < 8'd32) && ({2'b0, s[13:8]} < 8'd24)) && n < 70000) begin
      s = nx(s);
      n++;
    end
    cur_x = int'(s[6:0]);
    cur_y = int'(s[13:8]);
    cur_n = n;
    exp_q.push_back('{0, cur_x, cur_y});
  endtask

  always @(negedge pclk) begin
    if (rst_n) begin
      if (occ_req) hi_count++;
      if (occ_req && !prev_req) begin
        q_count++;
        pop(0, int'(occ_x), int'(occ_y), "query");
      end else if (occ_req) begin
        chk("query_hold_x", occ_x, hold_x);
        chk("query_hold_y", occ_y, hold_y);
      end
      if (apple_valid && !prev_av) pop(1, int'(apple_x), int'(apple_y), "apple");
      if (fail && !prev_fail) pop(2, int'(apple_valid), int'(busy), "fail");
    end
    prev_req  <= occ_req;
    prev_av   <= apple_valid;
    prev_fail <= fail;
    hold_x    <= occ_x;
    hold_y    <= occ_y;
  end

  always @(negedge pclk) begin
    if (s_rst_n && s_req && !s_prev) begin
      chk("sm_x_range", {31'd0, s_x < 7'd5}, 1);
      chk("sm_y_range", {31'd0, s_y < 6'd3}, 1);
    end
    s_prev <= s_req;
  end

  task automatic wait_req();
    int t;
    t = 0;
    while (!occ_req && t < 20000) begin
      @(negedge pclk);
      lat_k++;
      t++;
    end
    if (!occ_req) chk("req_timeout", occ_req, 1);
  endtask

  task automatic respond(input int nhit, input int dly, input bit exp_fail);
    bit last;
    for (int i = 0; i < 300; i++) begin
      wait_req();
      if (!occ_req) return;
      repeat (dly) begin
        @(negedge pclk);
        lat_k++;
      end
      occ_ack = 1'b1;
      occ_hit = (i < nhit);
      last = (i >= nhit) || (exp_fail && i == MT - 1);
      if (i >= nhit) exp_q.push_back('{1, cur_x, cur_y});
      else if (last) exp_q.push_back('{2, 0, 0});
      @(negedge pclk);
      lat_k++;
      occ_ack = 1'b0;
      occ_hit = 1'b0;
      if (last) return;
      predict();
    end
  endtask

  task automatic gen(input bit use_start, input int nhit, input bit exp_fail);
    @(negedge pclk);
    start = use_start;
    eaten = !use_start;
    @(negedge pclk);
    start = 1'b0;
    eaten = 1'b0;
    lat_k = 1;
    predict();
    lat_n = cur_n;
    respond(nhit, 0, exp_fail);
  endtask

  task automatic main_seq();
    int q0, h0;
    repeat (3) @(negedge pclk);
    chk("rst_occ_req", occ_req, 0);
    chk("rst_apple_valid", apple_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fail", fail, 0);
    chk("rst_apple_xy", {apple_x, apple_y}, 0);
    chk("rst_occ_xy", {occ_x, occ_y}, 0);
    rst_n = 1'b1;
    @(negedge pclk);
    chk("lfsr_step1", dut.lfsr_q, 16'hE270);
    repeat (99) @(negedge pclk);
    chk("idle_queries", q_count, 0);
    chk("idle_req_cycles", hi_count, 0);
    chk("idle_outputs", {occ_req, apple_valid, busy, fail}, 0);
    // best case: ack in the same cycle as the request
    h0 = hi_count;
    gen(1'b1, 0, 1'b0);
    chk("best_latency", lat_k, lat_n + 2);
    chk("best_req_cycles", hi_count - h0, 1);
    chk("best_valid", apple_valid, 1);
    chk("best_busy", busy, 0);
    chk("best_x_range", {31'd0, apple_x < 7'd32}, 1);
    chk("best_y_range", {31'd0, apple_y < 6'd24}, 1);
    // three occupied cells, fourth free, triggered by eaten
    q0 = q_count;
    gen(1'b0, 3, 1'b0);
    chk("retry_queries", q_count - q0, 4);
    chk("retry_fail", fail, 0);
    chk("retry_valid", apple_valid, 1);
    // every cell occupied: fail after MAX_TRIES requests
    q0 = q_count;
    gen(1'b1, 99, 1'b1);
    chk("fail_queries", q_count - q0, 4);
    chk("fail_flag", fail, 1);
    chk("fail_valid", apple_valid, 0);
    chk("fail_busy", busy, 0);
    @(negedge pclk);
    eaten = 1'b1;
    @(negedge pclk);
    eaten = 1'b0;
    repeat (20) @(negedge pclk);
    chk("fail_eaten_queries", q_count - q0, 4);
    chk("fail_eaten_flag", fail, 1);
    chk("fail_eaten_busy", busy, 0);
    q0 = q_count;
    gen(1'b1, 0, 1'b0);
    chk("fail_restart_queries", q_count - q0, 1);
    chk("fail_restart_flag", fail, 0);
    chk("fail_restart_valid", apple_valid, 1);
    // eaten during CHECK is ignored, start aborts and its same-cycle ack is dropped
    q0 = q_count;
    @(negedge pclk);
    start = 1'b1;
    @(negedge pclk);
    start = 1'b0;
    predict();
    wait_req();
    repeat (3) @(negedge pclk);
    eaten = 1'b1;
    @(negedge pclk);
    eaten = 1'b0;
    repeat (5) @(negedge pclk);
    chk("eaten_check_req", occ_req, 1);
    chk("eaten_check_queries", q_count - q0, 1);
    chk("eaten_check_busy", busy, 1);
    start = 1'b1;
    occ_ack = 1'b1;
    occ_hit = 1'b0;
    @(negedge pclk);
    start = 1'b0;
    chk("abort_req_drop", occ_req, 0);
    chk("abort_no_apple", apple_valid, 0);
    chk("abort_busy", busy, 1);
    predict();
    @(negedge pclk);
    occ_ack = 1'b0;
    respond(0, 0, 1'b0);
    chk("abort_queries", q_count - q0, 2);
    chk("abort_valid", apple_valid, 1);
    // reset in the middle of a query
    q0 = q_count;
    @(negedge pclk);
    start = 1'b1;
    @(negedge pclk);
    start = 1'b0;
    predict();
    wait_req();
    @(negedge pclk);
    rst_n = 1'b0;
    #1;
    chk("midrst_req", occ_req, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", apple_valid, 0);
    chk("midrst_apple_xy", {apple_x, apple_y}, 0);
    @(negedge pclk);
    rst_n = 1'b1;
    repeat (5) @(negedge pclk);
    chk("midrst_queries", q_count - q0, 1);
  endtask

  task automatic small_seq();
    bit seen [15];
    int nseen, cyc, t;
    nseen = 0;
    cyc = 0;
    repeat (3) @(negedge pclk);
    s_rst_n = 1'b1;
    for (int g = 0; g < 500 && nseen < 15 && cyc < 60000; g++) begin
      @(negedge pclk);
      if (g == 0) s_start = 1'b1;
      else s_eaten = 1'b1;
      @(negedge pclk);
      s_start = 1'b0;
      s_eaten = 1'b0;
      t = 0;
      while (!s_valid && t < 20000) begin
        @(negedge pclk);
        t++;
      end
      cyc += t + 2;
      if (!s_valid) begin
        chk("sm_timeout", s_valid, 1);
        break;
      end
      if (s_ax < 7'd5 && s_ay < 6'd3 && !seen[int'(s_ay) * 5 + int'(s_ax)]) begin
        seen[int'(s_ay) * 5 + int'(s_ax)] = 1'b1;
        nseen++;
      end
    end
    chk("sm_cover", nseen, 15);
    chk("sm_fail", s_fail, 0);
  endtask

  initial begin
    #1;
    rst_n = 1'b0;
    s_rst_n = 1'b0;
    fork
      main_seq();
      small_seq();
    join
    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
    $fatal(1);
  end
endmodule
